// File: rtl/ex_div_unit_if.sv
// Signal bundle between the EX-stage control and the iterative divider.
// start is a level held by EX until the cycle done pulses; stall_n=0 means EX and EX/MEM must hold.
interface ex_div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 cancel;
  logic [2*WIDTH-1:0]   hilo_out;
  logic                 done;
  logic                 busy;
  logic                 stall_n;
  logic [1:0]           dbg_state;

  modport slave (
    input  start, is_signed, dividend, divisor, cancel,
    output hilo_out, done, busy, stall_n, dbg_state
  );

  modport master (
    output start, is_signed, dividend, divisor, cancel,
    input  hilo_out, done, busy, stall_n, dbg_state
  );
endinterface

// File: rtl/ex_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, then a sign fix.
// Result {remainder, quotient} is registered and held until the next op completes.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rset,
  ex_div_unit_if.slave  div_if
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH-1:0]    r_quo;
  logic [WIDTH-1:0]    r_dvs;
  logic                r_q_neg;
  logic                r_r_neg;
  logic [2*WIDTH-1:0]  r_hilo;

  logic                w_accept;
  logic                w_div0;
  logic                w_last;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [WIDTH-1:0]    w_a_abs;
  logic [WIDTH-1:0]    w_b_abs;
  logic [WIDTH:0]      w_trial;
  logic [WIDTH:0]      w_diff;
  logic                w_ge;
  logic [WIDTH-1:0]    w_rem_nx;
  logic [WIDTH-1:0]    w_quo_nx;
  logic [WIDTH-1:0]    w_q_fix;
  logic [WIDTH-1:0]    w_r_fix;

  always_comb begin
    w_a_neg  = div_if.is_signed & div_if.dividend[WIDTH-1];
    w_b_neg  = div_if.is_signed & div_if.divisor[WIDTH-1];
    w_a_abs  = w_a_neg ? -div_if.dividend : div_if.dividend;
    w_b_abs  = w_b_neg ? -div_if.divisor  : div_if.divisor;
    w_accept = (r_state == S_IDLE) && div_if.start && !div_if.cancel;
    w_div0   = (div_if.divisor == '0);
    w_last   = (r_cnt == LAST);
    // r_quo doubles as the dividend shift register: its MSB feeds the remainder.
    w_trial  = {r_rem, r_quo[WIDTH-1]};
    w_diff   = w_trial - {1'b0, r_dvs};
    w_ge     = !w_diff[WIDTH];
    w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    w_q_fix  = r_q_neg ? -w_quo_nx : w_quo_nx;
    w_r_fix  = r_r_neg ? -w_rem_nx : w_rem_nx;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_div0 ? S_DONE : S_RUN;
      S_RUN:  if (w_last)   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (div_if.cancel) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_hilo  <= '0;
    end else if (w_accept) begin
      if (w_div0) begin
        r_hilo <= {div_if.dividend, {WIDTH{1'b1}}};
      end else begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_a_abs;
        r_dvs   <= w_b_abs;
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
      end
    end else if (r_state == S_RUN && !div_if.cancel) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_hilo <= {w_r_fix, w_q_fix};
    end
  end

  assign div_if.hilo_out  = r_hilo;
  assign div_if.done      = (r_state == S_DONE) && !div_if.cancel;
  assign div_if.busy      = (r_state == S_RUN);
  assign div_if.stall_n   = !rset || div_if.cancel || !(w_accept || r_state == S_RUN);
  assign div_if.dbg_state = r_state;
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: driver issues ops and checks latency/stall,
// a negedge monitor pops expected results whenever done pulses.
module tb_ex_div_unit;
  logic clk;
  logic rset;
  int   n_vec;
  int   n_err;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  ex_div_unit_if #(.WIDTH(32)) dif ();

  ex_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rset   (rset),
    .div_if (dif)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rset && dif.done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: hilo %h with no op pending at %0t", dif.hilo_out, $time);
      end else begin
        check("hilo_out", dif.hilo_out, exp_q.pop_front());
      end
    end
  end

  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
    int  cyc;
    int  low;
    bit  got;
    cyc = 0;
    low = 0;
    got = 0;
    @(posedge clk); #1;
    dif.start     = 1'b1;
    dif.is_signed = sg;
    dif.dividend  = a;
    dif.divisor   = b;
    exp_q.push_back(exp);
    last_exp = exp;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (!dif.stall_n) low++;
      if (dif.done) got = 1;
      else          cyc++;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done after %0d cycles, expected at cycle %0d", cyc, lat);
      exp_q.delete();
    end else begin
      check("done_cycle", 64'(cyc), 64'(lat));
      check("stall_cycles", 64'(low), 64'(lat));
    end
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_exp = '0;
    rset = 1'b0;
    dif.start = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    dif.cancel = 1'b0;

    vt[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,         32'd14},        33};
    vt[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vt[2]  = '{1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF,         32'h0FFF_FFFF}, 33};
    vt[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,         32'h8000_0000}, 33};
    vt[4]  = '{1'b0, 32'd5,          32'd0,          {32'd5,         32'hFFFF_FFFF}, 1};
    vt[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1};
    vt[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,         32'hFFFF_FFFD}, 33};
    vt[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},        33};
    vt[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0},         33};
    vt[9]  = '{1'b0, 32'd0,          32'd5,          {32'd0,         32'd0},         33};
    vt[10] = '{1'b0, 32'h1234_5678,  32'd1,          {32'd0,         32'h1234_5678}, 33};
    vt[11] = '{1'b0, 32'd3,          32'd5,          {32'd3,         32'd0},         33};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hilo",    dif.hilo_out, 64'h0);
    check("rst_done",    dif.done, 1'b0);
    check("rst_busy",    dif.busy, 1'b0);
    check("rst_stall_n", dif.stall_n, 1'b1);
    check("rst_state",   dif.dbg_state, 2'd0);
    @(posedge clk); #1;
    rset = 1'b1;

    for (int i = 0; i < 12; i++)
      do_div(vt[i].sg, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

    // cancel in RUN cycle 10
    @(posedge clk); #1;
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd1000; dif.divisor = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    dif.cancel = 1'b1;
    dif.start  = 1'b0;
    @(negedge clk);
    check("cancel_busy",    dif.busy, 1'b1);
    check("cancel_stall_n", dif.stall_n, 1'b1);
    check("cancel_done",    dif.done, 1'b0);
    @(posedge clk); #1;
    dif.cancel = 1'b0;
    @(negedge clk);
    check("cancel_state", dif.dbg_state, 2'd0);
    check("cancel_busy2", dif.busy, 1'b0);
    check("cancel_hilo",  dif.hilo_out, last_exp);
    repeat (40) @(negedge clk);
    check("cancel_hilo_held", dif.hilo_out, last_exp);

    // cancel together with start in IDLE
    @(posedge clk); #1;
    dif.start = 1'b1; dif.cancel = 1'b1; dif.dividend = 32'd5; dif.divisor = 32'd0;
    @(negedge clk);
    check("cs_stall_n", dif.stall_n, 1'b1);
    @(posedge clk); #1;
    dif.start = 1'b0; dif.cancel = 1'b0;
    @(negedge clk);
    check("cs_state", dif.dbg_state, 2'd0);
    check("cs_done",  dif.done, 1'b0);
    check("cs_hilo",  dif.hilo_out, last_exp);

    // async reset mid-RUN
    @(posedge clk); #1;
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    rset = 1'b0;
    dif.start = 1'b0;
    #1;
    check("arst_hilo",    dif.hilo_out, 64'h0);
    check("arst_done",    dif.done, 1'b0);
    check("arst_busy",    dif.busy, 1'b0);
    check("arst_stall_n", dif.stall_n, 1'b1);
    check("arst_state",   dif.dbg_state, 2'd0);
    @(posedge clk); #1;
    rset = 1'b1;
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    repeat (5) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
